memgame_enter_display: RTL and testbench
========================================

# memgame_enter_display

Enter-phase output path of the memorization game: compares the player's 16-bit entry with the target value, generates refresh and blink timing from the single system clock, and drives a 4-digit multiplexed seven-segment display. It sits between the random-number source and the player-input logic on one side and the board's anode/segment pins on the other. It shows one of three things: the target, the live entry, or a blinking PASS/FAIL verdict.

## Interface
Parameters:
- REFRESH_DIV, 100_000: clk cycles per digit slot. Must be ≥2.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period. Must be ≥2.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous reset, active-high.
- displayPhase  in  1  1 = show target (randInt).
- inputReady  in  1  1 = entry complete; show verdict.
- randInt  in  16  target value, 4 hex digits.
- userInput  in  16  player entry, 4 hex digits.
- correct  out  1  combinational, equals (userInput == randInt).
- anodeActivate  out  4  active-low digit enables. Bit 3 is the leftmost digit.
- LED_out  out  7  active-low segments, bit 6 = a through bit 0 = g.

## Operation
- Tick generator:
  - refresh counter counts 0..REFRESH_DIV-1 and wraps, pulsing refreshTick for one cycle at the wrap.
  - 2-bit digit select increments on each refreshTick, sequence 0→1→2→3→0.
  - blink counter counts 0..BLINK_DIV-1 and toggles blinkOn at each wrap.
- Digit select s drives anode 3-s low. Slot s shows nibble [15-4s:12-4s], so slot 0 is leftmost and shows [15:12].
- Mode priority:
  1. displayPhase=1: show randInt in hex, steady. Overrides inputReady.
  2. Else inputReady=1: show "PASS" if correct, otherwise "FAIL". Segments are blank (1111111) while blinkOn=0; the anode still scans.
  3. Else: show userInput in hex, steady.
- Hex glyphs, abcdefg, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Letters: P=0011000, A=0001000, S=0100100, F=0111000, I=1001111, L=1110001. Blank = 1111111.
- correct is purely combinational. It is not gated by inputReady.

## Timing
- Reset values:
  - all counters 0, digit select 0, blinkOn=1.
  - anodeActivate=4'b1111 and LED_out=7'b1111111 on the cycle after rst is sampled high.
- anodeActivate and LED_out are registered. Each updates one cycle after any change in digit select, mode inputs or data inputs.
- First cycle after reset release: outputs show slot 0 (anodeActivate=0111).
- The first refreshTick occurs REFRESH_DIV cycles after reset release. A full scan takes 4·REFRESH_DIV cycles.
- blinkOn first falls BLINK_DIV cycles after reset release. Verdict period is 2·BLINK_DIV cycles.
- Mode changes take effect on the next registered update and do not restart the scan or blink counters.
- Reset asserted mid-scan or mid-blink clears everything on the next edge, regardless of other inputs.
- Exactly one anode is low at any time outside reset.

## Structure
- Shared package `memgame_pkg`:
  - 16 hex glyph constants, letter constants and blank.
  - mode enum {SHOW_TARGET, SHOW_RESULT, SHOW_ENTRY}.
- Sub-module `memgame_tickgen` (parameters REFRESH_DIV and BLINK_DIV) holds both counters. It outputs refreshTick and blinkOn.
- The comparator, mode mux, glyph decode and output registers live in the top module.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_DIV=16.
- Reset: hold rst 3 cycles → anodeActivate=1111, LED_out=1111111. Cycle after release → anodeActivate=0111.
- Entry mode (displayPhase=0, inputReady=0, userInput=FFF4, randInt=1234) → slots 0..3 show 0111000, 0111000, 0111000, 1001100 on anodes 0111, 1011, 1101, 1110. Each digit holds for 4 cycles. correct=0.
- Target mode (displayPhase=1, inputReady=1, randInt=1234) → 1001111, 0010010, 0000110, 1001100, steady across 64 cycles.
- Verdict pass (displayPhase=0, inputReady=1, userInput=randInt=ABCD) → correct=1. P/A/S/S glyphs for 16 cycles, then 1111111 for 16 cycles, repeating.
- Verdict fail (userInput=ABCE) → correct=0. F/A/I/L glyphs with the same blink.
- Reset mid-operation: assert rst during slot 2 of a blank blink half → next cycle all outputs off. After release, slot 0 shows with blinkOn=1.

Source files
------------

// File: rtl/memgame_pkg.sv
// Shared constants and types for the memorization game display path:
// seven-segment glyphs (active-low, bit 6 = a ... bit 0 = g) and the display mode.
package memgame_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  localparam logic [6:0] LETTER_P = 7'b0011000;
  localparam logic [6:0] LETTER_A = 7'b0001000;
  localparam logic [6:0] LETTER_S = 7'b0100100;
  localparam logic [6:0] LETTER_F = 7'b0111000;
  localparam logic [6:0] LETTER_I = 7'b1001111;
  localparam logic [6:0] LETTER_L = 7'b1110001;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] ANODE_NONE = 4'b1111;

  typedef enum logic [1:0] {
    SHOW_TARGET,
    SHOW_RESULT,
    SHOW_ENTRY
  } mode_t;

  // Map one hex nibble to its seven-segment glyph.
  function automatic logic [6:0] hexGlyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/memgame_tickgen.sv
// Timing source for the display: a digit-refresh strobe and a slow blink phase,
// both derived from the single system clock.
module memgame_tickgen #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic refreshTick,
  output logic blinkOn
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] r_refreshCnt;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkOn;
  logic          w_refreshWrap;
  logic          w_blinkWrap;

  assign w_refreshWrap = (r_refreshCnt == REFRESH_MAX);
  assign w_blinkWrap   = (r_blinkCnt == BLINK_MAX);
  assign refreshTick   = w_refreshWrap;
  assign blinkOn       = r_blinkOn;

  // Free-running refresh and blink counters; blink phase starts "on" and flips at each blink wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refreshCnt <= '0;
      r_blinkCnt   <= '0;
      r_blinkOn    <= 1'b1;
    end else begin
      r_refreshCnt <= w_refreshWrap ? '0 : r_refreshCnt + 1'b1;
      r_blinkCnt   <= w_blinkWrap ? '0 : r_blinkCnt + 1'b1;
      if (w_blinkWrap) begin
        r_blinkOn <= ~r_blinkOn;
      end
    end
  end

endmodule

// File: rtl/memgame_enter_display.sv
// Enter-phase display driver: compares entry against target, picks what to show
// (target, live entry or blinking PASS/FAIL) and scans it onto a 4-digit display.
module memgame_enter_display
  import memgame_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        displayPhase,
  input  logic        inputReady,
  input  logic [15:0] randInt,
  input  logic [15:0] userInput,
  output logic        correct,
  output logic [3:0]  anodeActivate,
  output logic [6:0]  LED_out
);

  logic       w_refreshTick;
  logic       w_blinkOn;
  logic       w_correct;
  mode_t      w_mode;
  logic [3:0] w_targetNibble;
  logic [3:0] w_entryNibble;
  logic [6:0] w_letter;
  logic [6:0] w_segNext;
  logic [3:0] w_anodeNext;
  logic [1:0] r_digitSel;
  logic [3:0] r_anode;
  logic [6:0] r_led;

  memgame_tickgen #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) u_tickgen (
    .clk        (clk),
    .rst        (rst),
    .refreshTick(w_refreshTick),
    .blinkOn    (w_blinkOn)
  );

  assign w_correct     = (userInput == randInt);
  assign correct       = w_correct;
  assign w_anodeNext   = ~(4'b1000 >> r_digitSel);
  assign anodeActivate = r_anode;
  assign LED_out       = r_led;

  // Mode priority: showing the target wins, then the verdict, otherwise the live entry.
  always_comb begin
    w_mode = SHOW_ENTRY;
    if (displayPhase) begin
      w_mode = SHOW_TARGET;
    end else if (inputReady) begin
      w_mode = SHOW_RESULT;
    end
  end

  // Pick the nibble and verdict letter for the current slot; slot 0 is the leftmost digit.
  always_comb begin
    w_targetNibble = randInt[15:12];
    w_entryNibble  = userInput[15:12];
    w_letter       = w_correct ? LETTER_P : LETTER_F;
    case (r_digitSel)
      2'd0: begin
        w_targetNibble = randInt[15:12];
        w_entryNibble  = userInput[15:12];
        w_letter       = w_correct ? LETTER_P : LETTER_F;
      end
      2'd1: begin
        w_targetNibble = randInt[11:8];
        w_entryNibble  = userInput[11:8];
        w_letter       = LETTER_A;
      end
      2'd2: begin
        w_targetNibble = randInt[7:4];
        w_entryNibble  = userInput[7:4];
        w_letter       = w_correct ? LETTER_S : LETTER_I;
      end
      default: begin
        w_targetNibble = randInt[3:0];
        w_entryNibble  = userInput[3:0];
        w_letter       = w_correct ? LETTER_S : LETTER_L;
      end
    endcase
  end

  // Segment pattern for the current slot; the verdict goes dark during the off half of the blink.
  always_comb begin
    w_segNext = SEG_BLANK;
    case (w_mode)
      SHOW_TARGET: w_segNext = hexGlyph(w_targetNibble);
      SHOW_RESULT: w_segNext = w_blinkOn ? w_letter : SEG_BLANK;
      default:     w_segNext = hexGlyph(w_entryNibble);
    endcase
  end

  // Digit scan advances on each refresh strobe; anode and segment pins are registered to avoid glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digitSel <= 2'd0;
      r_anode    <= ANODE_NONE;
      r_led      <= SEG_BLANK;
    end else begin
      if (w_refreshTick) begin
        r_digitSel <= r_digitSel + 2'd1;
      end
      r_anode <= w_anodeNext;
      r_led   <= w_segNext;
    end
  end

endmodule

// File: tb/tb_memgame_enter_display.sv
// Randomized scoreboard bench for memgame_enter_display with a cycle-count reference model.
module tb_memgame_enter_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] led;
    logic       corr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        displayPhase;
  logic        inputReady;
  logic [15:0] randInt;
  logic [15:0] userInput;
  logic        correct;
  logic [3:0]  anodeActivate;
  logic [6:0]  LED_out;

  exp_t expQ[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  logic [6:0] hexTab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  memgame_enter_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .displayPhase (displayPhase),
    .inputReady   (inputReady),
    .randInt      (randInt),
    .userInput    (userInput),
    .correct      (correct),
    .anodeActivate(anodeActivate),
    .LED_out      (LED_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] letterGlyph(input byte c);
    case (c)
      "P": return 7'b0011000;
      "A": return 7'b0001000;
      "S": return 7'b0100100;
      "F": return 7'b0111000;
      "I": return 7'b1001111;
      "L": return 7'b1110001;
      default: return 7'b1111111;
    endcase
  endfunction

  // Drive one cycle of inputs and queue what the display must show after the coming edge.
  task automatic applyStimulus(input logic r, input logic dp, input logic ir,
                               input logic [15:0] ri, input logic [15:0] ui);
    exp_t  e;
    int    slot;
    bit    lit;
    string word;
    @(negedge clk);
    rst          = r;
    displayPhase = dp;
    inputReady   = ir;
    randInt      = ri;
    userInput    = ui;
    e.corr = (ui == ri);
    if (r) begin
      e.anode = 4'b1111;
      e.led   = 7'b1111111;
      cyc     = 0;
    end else begin
      slot    = (cyc / REFRESH_DIV) % 4;
      lit     = ((cyc / BLINK_DIV) % 2) == 0;
      cyc++;
      e.anode = 4'b1111;
      e.anode[3 - slot] = 1'b0;
      if (dp) begin
        e.led = hexTab[(ri >> (12 - 4 * slot)) & 16'hF];
      end else if (ir) begin
        word  = (ui == ri) ? "PASS" : "FAIL";
        e.led = lit ? letterGlyph(word[slot]) : 7'b1111111;
      end else begin
        e.led = hexTab[(ui >> (12 - 4 * slot)) & 16'hF];
      end
    end
    expQ.push_back(e);
  endtask

  // Compare the DUT pins against the oldest queued expectation.
  task automatic checkOutput();
    exp_t e;
    e = expQ.pop_front();
    vectors++;
    if (anodeActivate !== e.anode) begin
      miscompares++;
      $display("[TB] FAIL anode t=%0t got=%b want=%b", $time, anodeActivate, e.anode);
    end
    vectors++;
    if (LED_out !== e.led) begin
      miscompares++;
      $display("[TB] FAIL segments t=%0t got=%b want=%b", $time, LED_out, e.led);
    end
    vectors++;
    if (correct !== e.corr) begin
      miscompares++;
      $display("[TB] FAIL correct t=%0t got=%b want=%b", $time, correct, e.corr);
    end
  endtask

  // Monitor: sample shortly after every rising edge, decoupled from the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        checkOutput();
      end
    end
  end

  initial begin
    logic [15:0] ri;
    logic [15:0] ui;
    logic        dp;
    logic        ir;
    int          hold;
    rst = 1'b1; displayPhase = 1'b0; inputReady = 1'b0; randInt = '0; userInput = '0;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'hFFF4);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 16'hFFF4);
    repeat (64) applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 16'hFFF4);
    repeat (70) applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
    repeat (70) applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 16'hABCE);

    // Reset mid-blink: restart scan, then reset during slot 2 of the dark half.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hABCD, 16'hABCD);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 16'hABCD);

    // Randomized held segments with occasional reset pulses.
    for (int seg = 0; seg < 60; seg++) begin
      ri   = 16'($urandom);
      ui   = ($urandom_range(0, 2) == 0) ? ri : 16'($urandom);
      dp   = ($urandom_range(0, 3) == 0);
      ir   = ($urandom_range(0, 1) == 1);
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 3)) applyStimulus(1'b1, dp, ir, ri, ui);
      end
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          ui = 16'($urandom);
        end
        applyStimulus(1'b0, dp, ir, ri, ui);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain leftover=%0d want=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
